// File: rtl/iq_data_rotator_if.sv
// Sample/coefficient input bundle and rotated output bundle for iq_data_rotator.
// The master modport is the producer side; the rotator itself uses the slave modport.
interface iq_data_rotator_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int COEF_WIDTH    = 8,
  parameter int OUT_WIDTH     = 8,
  parameter int SAT_CNT_WIDTH = 16
);
  logic                         i_enable;
  logic                         i_valid;
  logic signed [DATA_WIDTH-1:0] i_dataI;
  logic signed [DATA_WIDTH-1:0] i_dataQ;
  logic signed [COEF_WIDTH-1:0] i_sin;
  logic signed [COEF_WIDTH-1:0] i_cos;
  logic                         i_bypass;
  logic                         i_clr_sat;
  logic                         o_valid;
  logic signed [OUT_WIDTH-1:0]  o_dataI;
  logic signed [OUT_WIDTH-1:0]  o_dataQ;
  logic                         o_sat_flag;
  logic [SAT_CNT_WIDTH-1:0]     o_sat_count;

  modport master (
    output i_enable, i_valid, i_dataI, i_dataQ, i_sin, i_cos, i_bypass, i_clr_sat,
    input  o_valid, o_dataI, o_dataQ, o_sat_flag, o_sat_count
  );

  modport slave (
    input  i_enable, i_valid, i_dataI, i_dataQ, i_sin, i_cos, i_bypass, i_clr_sat,
    output o_valid, o_dataI, o_dataQ, o_sat_flag, o_sat_count
  );
endinterface

// File: rtl/iq_data_rotator.sv
// Three-stage I/Q rotator: I' = I*cos - Q*sin, Q' = I*sin + Q*cos,
// with round-half-up, output saturation, per-sample bypass and a saturation event counter.
module iq_data_rotator #(
  parameter int DATA_WIDTH    = 8,
  parameter int COEF_WIDTH    = 8,
  parameter int COEF_FRAC     = 7,
  parameter int OUT_WIDTH     = 8,
  parameter int SAT_CNT_WIDTH = 16
) (
  input  logic            clock,
  input  logic            i_reset,
  iq_data_rotator_if.slave rot
);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  // one bit for the sum/difference plus one so the rounding add can never wrap
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] RND    = SW'(2 ** (COEF_FRAC - 1));
  localparam logic signed [SW-1:0] SAT_HI = SW'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;
  localparam logic [SAT_CNT_WIDTH-1:0] CNT_ONE = SAT_CNT_WIDTH'(1);

  logic                         s1_valid, s1_bypass;
  logic signed [DATA_WIDTH-1:0] s1_i, s1_q;
  logic signed [COEF_WIDTH-1:0] s1_sin, s1_cos;

  logic                         s2_valid, s2_bypass;
  logic signed [DATA_WIDTH-1:0] s2_i, s2_q;
  logic signed [PW-1:0]         p_ic, p_qs, p_is, p_qc;

  logic signed [SW-1:0]         sum_i, sum_q, pre_i, pre_q;
  logic                         sat_i, sat_q, sat_event;
  logic signed [OUT_WIDTH-1:0]  nxt_i, nxt_q;
  logic [SAT_CNT_WIDTH-1:0]     cnt_nxt;
  logic                         flag_nxt;

  logic                         out_valid;
  logic signed [OUT_WIDTH-1:0]  out_i, out_q;
  logic                         sat_flag;
  logic [SAT_CNT_WIDTH-1:0]     sat_count;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      s1_valid  <= 1'b0;
      s1_bypass <= 1'b0;
      s1_i      <= '0;
      s1_q      <= '0;
      s1_sin    <= '0;
      s1_cos    <= '0;
    end else if (rot.i_enable) begin
      s1_valid  <= rot.i_valid;
      s1_bypass <= rot.i_bypass;
      s1_i      <= rot.i_dataI;
      s1_q      <= rot.i_dataQ;
      s1_sin    <= rot.i_sin;
      s1_cos    <= rot.i_cos;
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      s2_valid  <= 1'b0;
      s2_bypass <= 1'b0;
      s2_i      <= '0;
      s2_q      <= '0;
      p_ic      <= '0;
      p_qs      <= '0;
      p_is      <= '0;
      p_qc      <= '0;
    end else if (rot.i_enable) begin
      s2_valid  <= s1_valid;
      s2_bypass <= s1_bypass;
      s2_i      <= s1_i;
      s2_q      <= s1_q;
      p_ic      <= s1_i * s1_cos;
      p_qs      <= s1_q * s1_sin;
      p_is      <= s1_i * s1_sin;
      p_qc      <= s1_q * s1_cos;
    end
  end

  // Bypass samples go through the same clamp: a no-op when OUT_WIDTH >= DATA_WIDTH,
  // a counted saturation otherwise.
  always_comb begin
    sum_i = SW'(p_ic) - SW'(p_qs);
    sum_q = SW'(p_is) + SW'(p_qc);
    if (s2_bypass) begin
      pre_i = SW'(s2_i);
      pre_q = SW'(s2_q);
    end else begin
      pre_i = (sum_i + RND) >>> COEF_FRAC;
      pre_q = (sum_q + RND) >>> COEF_FRAC;
    end
    sat_i = (pre_i > SAT_HI) || (pre_i < SAT_LO);
    sat_q = (pre_q > SAT_HI) || (pre_q < SAT_LO);
    nxt_i = pre_i[OUT_WIDTH-1:0];
    nxt_q = pre_q[OUT_WIDTH-1:0];
    if (sat_i) nxt_i = pre_i[SW-1] ? SAT_LO[OUT_WIDTH-1:0] : SAT_HI[OUT_WIDTH-1:0];
    if (sat_q) nxt_q = pre_q[SW-1] ? SAT_LO[OUT_WIDTH-1:0] : SAT_HI[OUT_WIDTH-1:0];
    sat_event = s2_valid && (sat_i || sat_q);
  end

  always_comb begin
    cnt_nxt  = sat_count;
    flag_nxt = sat_flag;
    if (rot.i_clr_sat) begin
      cnt_nxt  = sat_event ? CNT_ONE : '0;
      flag_nxt = sat_event;
    end else if (sat_event) begin
      if (sat_count != '1) cnt_nxt = sat_count + CNT_ONE;
      flag_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      sat_flag  <= 1'b0;
      sat_count <= '0;
    end else if (rot.i_enable) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_i <= nxt_i;
        out_q <= nxt_q;
      end
      sat_count <= cnt_nxt;
      sat_flag  <= flag_nxt;
    end
  end

  assign rot.o_valid     = out_valid;
  assign rot.o_dataI     = out_i;
  assign rot.o_dataQ     = out_q;
  assign rot.o_sat_flag  = sat_flag;
  assign rot.o_sat_count = sat_count;
endmodule

// File: tb/tb_iq_data_rotator.sv
// Directed and randomized bench for iq_data_rotator against an arithmetic reference
// model that tracks samples per enabled clock.
module tb_iq_data_rotator;
  logic clock = 1'b0;
  logic i_reset;
  always #5 clock = ~clock;

  iq_data_rotator_if #(.DATA_WIDTH(8), .COEF_WIDTH(8), .OUT_WIDTH(8), .SAT_CNT_WIDTH(16)) bus ();

  iq_data_rotator #(
    .DATA_WIDTH(8), .COEF_WIDTH(8), .COEF_FRAC(7), .OUT_WIDTH(8), .SAT_CNT_WIDTH(16)
  ) dut (
    .clock(clock),
    .i_reset(i_reset),
    .rot(bus)
  );

  typedef struct {
    bit v;
    bit byp;
    int i, q, s, c;
  } samp_t;

  samp_t pipe[$];
  int    checks = 0;
  int    failures = 0;
  int    e_valid, e_i, e_q, e_cnt, e_flag;

  function automatic int clamp8(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  // round half up: floor((x + 64) / 128)
  function automatic int round7(input int x);
    return (x + 64) >>> 7;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit en, input bit v, input bit byp, input bit clr,
                       input int di, input int dq, input int s, input int c);
    bus.i_enable  = en;
    bus.i_valid   = v;
    bus.i_bypass  = byp;
    bus.i_clr_sat = clr;
    bus.i_dataI   = 8'(di);
    bus.i_dataQ   = 8'(dq);
    bus.i_sin     = 8'(s);
    bus.i_cos     = 8'(c);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic model_update();
    samp_t n, o, bubble;
    int ri, rq, ci, cq;
    bit ev;
    bubble = '{default: 0};
    if (i_reset) begin
      pipe.delete();
      pipe.push_back(bubble);
      pipe.push_back(bubble);
      e_valid = 0; e_i = 0; e_q = 0; e_cnt = 0; e_flag = 0;
    end else if (bus.i_enable) begin
      n.v = bus.i_valid; n.byp = bus.i_bypass;
      n.i = bus.i_dataI; n.q = bus.i_dataQ; n.s = bus.i_sin; n.c = bus.i_cos;
      pipe.push_back(n);
      o = pipe.pop_front();
      ev = 1'b0;
      if (o.v) begin
        if (o.byp) begin
          ri = o.i; rq = o.q;
        end else begin
          ri = round7(o.i * o.c - o.q * o.s);
          rq = round7(o.i * o.s + o.q * o.c);
        end
        ci = clamp8(ri); cq = clamp8(rq);
        ev = (ci != ri) || (cq != rq);
        e_i = ci; e_q = cq;
      end
      e_valid = o.v;
      if (bus.i_clr_sat) begin
        e_cnt = ev; e_flag = ev;
      end else if (ev) begin
        if (e_cnt < 65535) e_cnt++;
        e_flag = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
    chk("valid", bus.o_valid, e_valid);
    chk("dataI", bus.o_dataI, e_i);
    chk("dataQ", bus.o_dataQ, e_q);
    chk("sat_flag", bus.o_sat_flag, e_flag);
    chk("sat_count", bus.o_sat_count, e_cnt);
  endtask

  task automatic expect_now(input string tag, input int v, input int di, input int dq,
                            input int cnt, input int flag);
    chk({tag, "_valid"}, bus.o_valid, v);
    chk({tag, "_I"}, bus.o_dataI, di);
    chk({tag, "_Q"}, bus.o_dataQ, dq);
    chk({tag, "_cnt"}, bus.o_sat_count, cnt);
    chk({tag, "_flag"}, bus.o_sat_flag, flag);
  endtask

  initial begin
    i_reset = 1'b1;
    idle();
    tick();
    tick();
    expect_now("reset", 0, 0, 0, 0, 0);
    i_reset = 1'b0;

    // identity rotation
    drive(1, 1, 0, 0, 64, -32, 0, 127);
    tick(); idle(); tick(); tick();
    expect_now("t1", 1, 64, -32, 0, 0);

    // quarter-turn rotation
    drive(1, 1, 0, 0, 64, -32, 127, 0);
    tick(); idle(); tick(); tick();
    expect_now("t2", 1, 32, 64, 0, 0);

    // positive then negative saturation, back to back
    drive(1, 1, 0, 0, 127, -128, 127, 127);
    tick();
    drive(1, 1, 0, 0, -128, 127, 127, 127);
    tick(); idle(); tick();
    expect_now("t3a", 1, 127, -1, 1, 1);
    tick();
    chk("t3b_I", bus.o_dataI, -128);
    chk("t3b_cnt", bus.o_sat_count, 2);
    tick();
    chk("t3_hold_valid", bus.o_valid, 0);

    // five-sample stream with a four-cycle enable drop in the middle
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        for (int j = 0; j < 4; j++) begin
          drive(0, 1, 0, 1, $urandom_range(0, 255), $urandom_range(0, 255), 5, 9);
          tick();
        end
      end
      drive(1, 1, 0, 0, 10 * k + 3, -7 * k, $urandom_range(0, 255), $urandom_range(0, 255));
      tick();
    end
    idle(); tick(); tick(); tick();

    // clear coinciding with a saturating output, then a plain clear
    drive(1, 1, 0, 0, 127, -128, 127, 127);
    tick(); idle(); tick();
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    tick();
    chk("t5_clr_sat_cnt", bus.o_sat_count, 1);
    chk("t5_clr_sat_flag", bus.o_sat_flag, 1);
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    tick();
    chk("t5_clr_cnt", bus.o_sat_count, 0);
    chk("t5_clr_flag", bus.o_sat_flag, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255));
      tick();
    end

    // reset with samples in flight and i_enable low
    drive(1, 1, 0, 0, 127, 127, 127, 127);
    tick();
    drive(1, 1, 0, 0, -128, -128, 127, 127);
    tick();
    i_reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_now("t6_reset", 0, 0, 0, 0, 0);
    i_reset = 1'b0;
    idle(); tick(); tick();
    chk("t6_flushed", bus.o_valid, 0);

    // bypass ignores coefficients
    drive(1, 1, 1, 0, -5, 100, 127, 127);
    tick(); idle(); tick(); tick();
    expect_now("t6_bypass", 1, -5, 100, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
